// File: rtl/uib_arb_pkg.sv
// Shared types and defaults for the two-master UIB arbiter.
package uib_arb_pkg;

  localparam int unsigned DefXlen    = 32;
  localparam int unsigned DefAddrW   = 32;
  localparam int unsigned DefLockMax = 16;

  // Master identifier: 0 = port 0, 1 = port 1.
  typedef logic mid_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uib_rr_pick.sv
// Combinational 2-way round-robin picker with an owner override.
module uib_rr_pick
  import uib_arb_pkg::*;
(
  input  logic [1:0] req,
  input  mid_t       last,
  input  logic       force_en,
  input  mid_t       force_id,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (force_en) begin
      // Only the lock owner may be granted; the other master simply waits.
      gnt[force_id] = req[force_id];
    end else if (req == 2'b11) begin
      gnt[~last] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/uib_arbiter.sv
// Two-master round-robin arbiter in front of one UIB slave, with 1-cycle read return.
// Optional lock/ownership with timeout is built when UIB_ARB_LOCK_EN is defined.
module uib_arbiter
  import uib_arb_pkg::*;
#(
  parameter int unsigned XLEN     = DefXlen,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned MODE_W   = XLEN / 8,
  parameter int unsigned LOCK_MAX = DefLockMax
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [XLEN-1:0]   m0_dat_i,
  input  logic [MODE_W-1:0] m0_mode,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [XLEN-1:0]   m0_dat_o,

  input  logic              m1_req,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [XLEN-1:0]   m1_dat_i,
  input  logic [MODE_W-1:0] m1_mode,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [XLEN-1:0]   m1_dat_o,

  output logic              s_req,
  output logic              s_wen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [XLEN-1:0]   s_dat_o,
  output logic [MODE_W-1:0] s_mode,
  input  logic [XLEN-1:0]   s_dat_i,

  output logic              lock_err
);

  if ((XLEN % 8) != 0) begin : g_bad_xlen
    $error("XLEN must be a multiple of 8");
  end
  if (LOCK_MAX < 1) begin : g_bad_lock_max
    $error("LOCK_MAX must be at least 1");
  end

  logic [1:0] req;
  logic [1:0] gnt;
  mid_t       sel;
  logic       force_en;
  mid_t       force_id;

  logic rpend_q, rpend_d;
  mid_t rsel_q, rsel_d;
  mid_t last_q, last_d;

  // Requests are masked during reset so every output reads 0 while rst is high.
  assign req = {m1_req, m0_req} & {2{~rst}};

  uib_rr_pick u_pick (
    .req      (req),
    .last     (last_q),
    .force_en (force_en),
    .force_id (force_id),
    .gnt      (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];
  assign sel    = gnt[1];

  always_comb begin
    s_req   = |gnt;
    s_wen   = 1'b0;
    s_addr  = '0;
    s_dat_o = '0;
    s_mode  = '0;
    if (gnt[0]) begin
      s_wen   = m0_wen;
      s_addr  = m0_addr;
      s_dat_o = m0_dat_i;
      s_mode  = m0_mode;
    end else if (gnt[1]) begin
      s_wen   = m1_wen;
      s_addr  = m1_addr;
      s_dat_o = m1_dat_i;
      s_mode  = m1_mode;
    end
  end

  always_comb begin
    last_d  = last_q;
    rpend_d = 1'b0;
    rsel_d  = rsel_q;
    if (|gnt) begin
      last_d  = sel;
      rpend_d = ~s_wen;
      rsel_d  = sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpend_q <= 1'b0;
      rsel_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      rpend_q <= rpend_d;
      rsel_q  <= rsel_d;
      last_q  <= last_d;
    end
  end

  assign m0_rvalid = rpend_q & (rsel_q == 1'b0);
  assign m1_rvalid = rpend_q & (rsel_q == 1'b1);
  assign m0_dat_o  = m0_rvalid ? s_dat_i : '0;
  assign m1_dat_o  = m1_rvalid ? s_dat_i : '0;

`ifdef UIB_ARB_LOCK_EN
  localparam int unsigned      CntW    = $clog2(LOCK_MAX + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_MAX - 1);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lock_err_q, lock_err_d;
  mid_t            own_id;
  logic            own_gnt;
  logic            own_lock;

  assign own_id   = mid_t'(state_q == StOwn1);
  assign force_en = (state_q != StIdle);
  assign force_id = own_id;
  assign own_gnt  = gnt[own_id];
  assign own_lock = own_id ? m1_lock : m0_lock;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lock_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (gnt[0] && m0_lock) begin
          state_d = StOwn0;
        end else if (gnt[1] && m1_lock) begin
          state_d = StOwn1;
        end
      end
      StOwn0, StOwn1: begin
        if (own_gnt && !own_lock) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          // This is the LOCK_MAX-th owned cycle: its access completes, then ownership ends.
          state_d    = StIdle;
          cnt_d      = '0;
          lock_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign lock_err = lock_err_q;
`else
  // Lock inputs are accepted but have no effect in this build.
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
  assign force_en    = 1'b0;
  assign force_id    = 1'b0;
  assign lock_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uib_arbiter.sv
// Directed self-checking bench for uib_arbiter with a small byte-lane slave memory.
module tb_uib_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wen, m0_lock, m1_req, m1_wen, m1_lock;
  logic [31:0] m0_addr, m0_dat_i, m1_addr, m1_dat_i;
  logic [3:0]  m0_mode, m1_mode;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_req, s_wen;
  logic [31:0] s_addr, s_dat_o, s_dat_i;
  logic [3:0]  s_mode;
  logic        lock_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  uib_arbiter #(
    .XLEN     (32),
    .ADDR_W   (32),
    .MODE_W   (4),
    .LOCK_MAX (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_wen    (m0_wen),
    .m0_addr   (m0_addr),
    .m0_dat_i  (m0_dat_i),
    .m0_mode   (m0_mode),
    .m0_lock   (m0_lock),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_dat_o  (m0_dat_o),
    .m1_req    (m1_req),
    .m1_wen    (m1_wen),
    .m1_addr   (m1_addr),
    .m1_dat_i  (m1_dat_i),
    .m1_mode   (m1_mode),
    .m1_lock   (m1_lock),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_dat_o  (m1_dat_o),
    .s_req     (s_req),
    .s_wen     (s_wen),
    .s_addr    (s_addr),
    .s_dat_o   (s_dat_o),
    .s_mode    (s_mode),
    .s_dat_i   (s_dat_i),
    .lock_err  (lock_err)
  );

  // Slave: word-indexed by addr[5:2], byte-lane writes, read data one cycle after s_req.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
      s_dat_i <= '0;
    end else if (s_req) begin
      if (s_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (s_mode[b]) mem[s_addr[5:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
        end
      end else begin
        s_dat_i <= mem[s_addr[5:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_wen = 0; m0_lock = 0; m0_addr = 0; m0_dat_i = 0; m0_mode = 0;
    m1_req = 0; m1_wen = 0; m1_lock = 0; m1_addr = 0; m1_dat_i = 0; m1_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_req, s_wen, lock_err}, 0);
    chk("rst_s_bus", {s_addr, s_dat_o}, 0);
    chk("rst_m_dat", {m0_dat_o, m1_dat_o}, 0);
    rst = 1'b0;

    // Single master read.
    m0_req = 1; m0_wen = 0; m0_addr = 32'h10; m0_mode = 4'hF;
    #1;
    chk("t1_m0_gnt", m0_gnt, 1);
    chk("t1_m1_gnt", m1_gnt, 0);
    chk("t1_s_req", s_req, 1);
    chk("t1_s_addr", s_addr, 32'h10);
    chk("t1_s_wen", s_wen, 0);
    chk("t1_s_mode", s_mode, 4'hF);
    tick();
    m0_req = 0;
    #1;
    chk("t1_m0_rvalid", m0_rvalid, 1);
    chk("t1_m0_dat", m0_dat_o, 32'hA000_0004);
    chk("t1_m1_quiet", {m1_rvalid, m1_dat_o}, 0);
    chk("t1_idle_bus", {s_req, s_addr}, 0);
    tick();

    // Back-to-back write then read on m1, partial-lane write.
    m1_req = 1; m1_wen = 1; m1_addr = 32'h20; m1_dat_i = 32'hDEAD_BEEF; m1_mode = 4'h3;
    #1;
    chk("b2b_wr_gnt", {m1_gnt, m0_gnt}, 2'b10);
    chk("b2b_wr_wen", s_wen, 1);
    chk("b2b_wr_dat", s_dat_o, 32'hDEAD_BEEF);
    chk("b2b_wr_mode", s_mode, 4'h3);
    tick();
    m1_wen = 0; m1_dat_i = 0; m1_mode = 4'hF;
    #1;
    chk("b2b_rd_gnt", m1_gnt, 1);
    chk("b2b_rd_wen", s_wen, 0);
    chk("b2b_wr_no_rvalid", m1_rvalid, 0);
    tick();
    m1_req = 0;
    #1;
    chk("b2b_rd_rvalid", m1_rvalid, 1);
    chk("b2b_rd_dat", m1_dat_o, 32'hA000_BEEF);
    chk("b2b_m0_quiet", m0_rvalid, 0);
    tick();

    // Contention: both masters read every cycle; m1 was granted last.
    m0_req = 1; m0_wen = 0; m0_addr = 32'h00; m0_mode = 4'hF;
    m1_req = 1; m1_wen = 0; m1_addr = 32'h04; m1_mode = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr_m0_gnt_%0d", i), m0_gnt, (i % 2) == 0);
      chk($sformatf("rr_m1_gnt_%0d", i), m1_gnt, (i % 2) == 1);
      if (i > 0) begin
        chk($sformatf("rr_m0_rv_%0d", i), {m0_rvalid, m0_dat_o},
            ((i - 1) % 2 == 0) ? {1'b1, 32'hA000_0000} : 33'd0);
        chk($sformatf("rr_m1_rv_%0d", i), {m1_rvalid, m1_dat_o},
            ((i - 1) % 2 == 1) ? {1'b1, 32'hA000_0001} : 33'd0);
      end
      tick();
    end
    m0_req = 0; m1_req = 0;
    #1;
    chk("rr_last_rv", {m1_rvalid, m1_dat_o}, {1'b1, 32'hA000_0001});
    chk("rr_last_m0", m0_rvalid, 0);
    tick();

`ifdef UIB_ARB_LOCK_EN
    // Locked read-modify-write on m0 while m1 keeps requesting.
    m0_req = 1; m0_wen = 0; m0_lock = 1; m0_addr = 32'h0C;
    m1_req = 1;
    #1;
    chk("lk_c1_gnt", {m1_gnt, m0_gnt}, 2'b01);
    tick();
    m0_req = 0;
    #1;
    chk("lk_c2_m1_wait", m1_gnt, 0);
    chk("lk_c2_rv", {m0_rvalid, m0_dat_o}, {1'b1, 32'hA000_0003});
    tick();
    m0_req = 1; m0_wen = 1; m0_lock = 0; m0_dat_i = 32'h1234_5678;
    #1;
    chk("lk_c3_gnt", {m1_gnt, m0_gnt}, 2'b01);
    tick();
    m0_req = 0;
    #1;
    chk("lk_c4_m1_gnt", m1_gnt, 1);
    tick();
    m1_req = 0;
    #1;
    chk("lk_c5_rv", {m1_rvalid, m1_dat_o}, {1'b1, 32'hA000_0001});
    tick();

    // Lock timeout: m0 holds lock for 20 cycles, m1 requests throughout.
    m0_req = 1; m0_wen = 0; m0_lock = 1; m0_addr = 32'h00;
    m1_req = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("to_err_%0d", i), lock_err, i == 17);
      chk($sformatf("to_m0_%0d", i), m0_gnt, i != 17);
      chk($sformatf("to_m1_%0d", i), m1_gnt, i == 17);
      tick();
    end
    m0_lock = 0; m1_req = 0;
    #1;
    chk("to_unlock_gnt", m0_gnt, 1);
    chk("to_unlock_err", lock_err, 0);
    tick();
    m0_req = 0; m1_req = 1;
    #1;
    chk("to_idle_m1", m1_gnt, 1);
    chk("to_idle_err", lock_err, 0);
    tick();
    m1_req = 0;
    tick();
`else
    // Lock requests are ignored: round-robin continues.
    m0_req = 1; m0_wen = 0; m0_lock = 1; m0_addr = 32'h00;
    m1_req = 1;
    #1;
    chk("nl_c1_gnt", {m1_gnt, m0_gnt}, 2'b01);
    tick();
    #1;
    chk("nl_c2_gnt", {m1_gnt, m0_gnt}, 2'b10);
    chk("nl_err", lock_err, 0);
    tick();
    m0_req = 0; m0_lock = 0; m1_req = 0;
    tick();
`endif

    // Reset in the cycle after a read grant drops the pending rvalid.
    m0_req = 1; m0_wen = 0; m0_addr = 32'h10;
    #1;
    chk("rs_gnt", m0_gnt, 1);
    tick();
    m0_req = 0; m1_req = 1; m1_wen = 0; m1_addr = 32'h04;
    rst = 1'b1;
    #1;
    chk("rs_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rs_dat", {m0_dat_o, m1_dat_o}, 0);
    chk("rs_bus", {m0_gnt, m1_gnt, s_req, s_wen, lock_err}, 0);
    chk("rs_s_addr", s_addr, 0);
    tick();
    m1_req = 0;
    rst = 1'b0;
    #1;
    chk("rs_no_reissue", {m0_rvalid, m1_rvalid}, 0);
    tick();
    #1;
    chk("rs_no_reissue2", {m0_rvalid, m1_rvalid, s_req}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
